// File: rtl/wm8731_cfg_seq_if.sv
// Handshake bundle between the WM8731 configuration sequencer and the
// I2C write core.
//   I2C_ENABLE   : sequencer -> core, request one register write
//   I2C_DATA     : sequencer -> core, {7-bit reg addr, 9-bit data}
//   I2C_FINISHED : core -> sequencer, write complete (slow-tick domain)
interface wm8731_cfg_seq_if;
  logic        I2C_ENABLE;
  logic [15:0] I2C_DATA;
  logic        I2C_FINISHED;

  modport master (
    output I2C_ENABLE,
    output I2C_DATA,
    input  I2C_FINISHED
  );

  modport slave (
    input  I2C_ENABLE,
    input  I2C_DATA,
    output I2C_FINISHED
  );
endinterface

// File: rtl/wm8731_cfg_seq.sv
// Power-up configuration sequencer for the WM8731 codec. Walks an 11-entry
// register table and hands one word at a time to the I2C write core.
//   MCLK   : system clock
//   RESET  : asynchronous active-low reset
//   START  : one-cycle pulse, (re)runs the table from word 0 when idle/done/error
//   i2c    : ENABLE/DATA/FINISHED handshake to the I2C core (master side)
//   BUSY   : sequence running
//   DONE   : all words written, cleared by START
//   ERROR  : a word timed out waiting for FINISHED, cleared by START
//   INDEX  : current table index 0..10
module wm8731_cfg_seq #(
  parameter int unsigned GAP_CYCLES     = 2048,
  parameter int unsigned TIMEOUT_CYCLES = 65536,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                    MCLK,
  input  logic                    RESET,
  input  logic                    START,
  wm8731_cfg_seq_if.master        i2c,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ERROR,
  output logic [3:0]              INDEX
);

  localparam int unsigned   CNT_MAX    = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned   CW         = $clog2(CNT_MAX);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
  // The S_LOAD cycle also has ENABLE low, so the gap state ends one cycle
  // early to keep the total ENABLE-low time at exactly GAP_CYCLES.
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 2);
  localparam logic [3:0]    LAST_INDEX = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_XFER,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          enable_q, enable_nx;
  logic [15:0]   data_q, data_nx;
  logic          busy_nx, done_nx, error_nx;
  logic [3:0]    index_nx;
  logic          fin_meta, fin_sync, fin_prev, fin_pulse;

  function automatic logic [15:0] cfg_word(input logic [3:0] idx);
    logic [15:0] w;
    case (idx)
      4'd0:    w = 16'h1E00; // reset
      4'd1:    w = 16'h0017; // left line in
      4'd2:    w = 16'h0217; // right line in
      4'd3:    w = 16'h047B; // left headphone
      4'd4:    w = 16'h067B; // right headphone
      4'd5:    w = 16'h0812; // analog path
      4'd6:    w = 16'h0A06; // digital path
      4'd7:    w = 16'h0C00; // power down control
      4'd8:    w = 16'h0E02; // I2S, 16-bit
      4'd9:    w = 16'h1000; // sampling control
      4'd10:   w = 16'h1201; // active
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  assign i2c.I2C_ENABLE = enable_q;
  assign i2c.I2C_DATA   = data_q;

  // FINISHED comes from the slow-tick domain; synchronise and edge-detect.
  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      fin_meta <= 1'b0;
      fin_sync <= 1'b0;
      fin_prev <= 1'b0;
    end else begin
      fin_meta <= i2c.I2C_FINISHED;
      fin_sync <= fin_meta;
      fin_prev <= fin_sync;
    end
  end

  assign fin_pulse = fin_sync & ~fin_prev;

  always_ff @(posedge MCLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      cnt      <= '0;
      enable_q <= 1'b0;
      data_q   <= '0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERROR    <= 1'b0;
      INDEX    <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      enable_q <= enable_nx;
      data_q   <= data_nx;
      BUSY     <= busy_nx;
      DONE     <= done_nx;
      ERROR    <= error_nx;
      INDEX    <= index_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    enable_nx = enable_q;
    data_nx   = data_q;
    busy_nx   = BUSY;
    done_nx   = DONE;
    error_nx  = ERROR;
    index_nx  = INDEX;
    unique case (state)
      S_IDLE: begin
        if (AUTO_START || START) begin
          index_nx = '0;
          busy_nx  = 1'b1;
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        data_nx   = cfg_word(INDEX);
        enable_nx = 1'b1;
        cnt_nx    = '0;
        state_nx  = S_XFER;
      end
      S_XFER: begin
        // A FINISHED edge in the last allowed cycle still counts as success.
        if (fin_pulse) begin
          enable_nx = 1'b0;
          cnt_nx    = '0;
          state_nx  = S_GAP;
        end else if (cnt == TO_LAST) begin
          enable_nx = 1'b0;
          error_nx  = 1'b1;
          busy_nx   = 1'b0;
          state_nx  = S_ERR;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_nx = '0;
          if (INDEX == LAST_INDEX) begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = S_DONE;
          end else begin
            index_nx = INDEX + 4'd1;
            state_nx = S_LOAD;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DONE, S_ERR: begin
        if (START) begin
          index_nx = '0;
          done_nx  = 1'b0;
          error_nx = 1'b0;
          busy_nx  = 1'b1;
          state_nx = S_LOAD;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Directed bench for wm8731_cfg_seq: one auto-start instance and one
// START-triggered instance, each driven by a behavioural I2C core.
module tb_wm8731_cfg_seq;

  localparam int GAP_A = 2048;
  localparam int TO_A  = 8192;
  localparam int GAP_B = 1024;
  localparam int TO_B  = 4096;
  localparam int LAT_A = 200;
  localparam int LAT_B = 100;
  localparam int FIN_W = 512;
  localparam logic [15:0] EXP [11] = '{16'h1E00, 16'h0017, 16'h0217, 16'h047B,
                                       16'h067B, 16'h0812, 16'h0A06, 16'h0C00,
                                       16'h0E02, 16'h1000, 16'h1201};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic fin_a = 1'b0;
  logic fin_b = 1'b0;
  logic busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [3:0] index_a, index_b;

  int n_cmp = 0;
  int n_bad = 0;

  wm8731_cfg_seq_if ifa ();
  wm8731_cfg_seq_if ifb ();

  assign ifa.I2C_FINISHED = fin_a;
  assign ifb.I2C_FINISHED = fin_b;

  wm8731_cfg_seq #(.GAP_CYCLES(GAP_A), .TIMEOUT_CYCLES(TO_A), .AUTO_START(1'b1)) u_auto (
    .MCLK(clk), .RESET(rst_n), .START(start_a), .i2c(ifa.master),
    .BUSY(busy_a), .DONE(done_a), .ERROR(err_a), .INDEX(index_a)
  );

  wm8731_cfg_seq #(.GAP_CYCLES(GAP_B), .TIMEOUT_CYCLES(TO_B), .AUTO_START(1'b0)) u_man (
    .MCLK(clk), .RESET(rst_n), .START(start_b), .i2c(ifb.master),
    .BUSY(busy_b), .DONE(done_b), .ERROR(err_b), .INDEX(index_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural I2C cores: capture DATA on ENABLE, answer after a latency
  // with a FIN_W-wide FINISHED, then require ENABLE low before going idle.
  logic [15:0] log_a[$];
  logic [15:0] log_b[$];
  int nofin_a = -1;
  int ms_a = 0, cnt_a = 0, ms_b = 0, cnt_b = 0;

  always @(negedge clk) begin
    case (ms_a)
      0: if (ifa.I2C_ENABLE) begin log_a.push_back(ifa.I2C_DATA); cnt_a = 0; ms_a = 1; end
      1: if (!ifa.I2C_ENABLE) ms_a = 0;
         else if (cnt_a == LAT_A) begin
           if (int'(log_a.size()) - 1 != nofin_a) begin fin_a = 1'b1; cnt_a = 0; ms_a = 2; end
         end else cnt_a++;
      2: if (cnt_a == FIN_W - 1) begin
           fin_a = 1'b0;
           check("a_core_sees_enable_low", 32'(ifa.I2C_ENABLE), 32'd0);
           ms_a = 3;
         end else cnt_a++;
      default: if (!ifa.I2C_ENABLE) ms_a = 0;
    endcase
  end

  always @(negedge clk) begin
    case (ms_b)
      0: if (ifb.I2C_ENABLE) begin log_b.push_back(ifb.I2C_DATA); cnt_b = 0; ms_b = 1; end
      1: if (!ifb.I2C_ENABLE) ms_b = 0;
         else if (cnt_b == LAT_B) begin fin_b = 1'b1; cnt_b = 0; ms_b = 2; end
         else cnt_b++;
      2: if (cnt_b == FIN_W - 1) begin
           fin_b = 1'b0;
           check("b_core_sees_enable_low", 32'(ifb.I2C_ENABLE), 32'd0);
           ms_b = 3;
         end else cnt_b++;
      default: if (!ifb.I2C_ENABLE) ms_b = 0;
    endcase
  end

  // Cycle monitor: ENABLE-low gap length, rise/error timestamps, B activity.
  int cyc = 0, last_rise_a = 0, err_rise_a = 0, low_a = -1, b_rises = 0;
  logic en_prev_a = 1'b0, en_prev_b = 1'b0, err_prev_a = 1'b0;
  bit gap_on = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (ifa.I2C_ENABLE && !en_prev_a) begin
      last_rise_a = cyc;
      if (gap_on && low_a >= 0) check("a_gap_len", 32'(low_a), 32'(GAP_A));
      low_a = -1;
    end else if (!ifa.I2C_ENABLE) begin
      if (en_prev_a) low_a = 1;
      else if (low_a >= 0) low_a++;
    end
    if (!gap_on) low_a = -1;
    if (err_a && !err_prev_a) err_rise_a = cyc;
    if (ifb.I2C_ENABLE && !en_prev_b) b_rises++;
    en_prev_a  = ifa.I2C_ENABLE;
    en_prev_b  = ifb.I2C_ENABLE;
    err_prev_a = err_a;
  end

  task automatic pulse_start_a();
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_enable", 32'(ifa.I2C_ENABLE), 32'd0);
    check("rst_data",   32'(ifa.I2C_DATA),   32'h0000);
    check("rst_busy",   32'(busy_a),         32'd0);
    check("rst_done",   32'(done_a),         32'd0);
    check("rst_error",  32'(err_a),          32'd0);
    check("rst_index",  32'(index_a),        32'd0);

    // Auto-start full sequence
    gap_on = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check("auto_load_busy",   32'(busy_a),         32'd1);
    check("auto_load_enable", 32'(ifa.I2C_ENABLE), 32'd0);
    @(negedge clk);
    check("auto_xfer_enable", 32'(ifa.I2C_ENABLE), 32'd1);
    check("auto_xfer_data",   32'(ifa.I2C_DATA),   32'h1E00);
    n = 0;
    while (!done_a && n < 40000) begin @(negedge clk); n++; end
    #1;
    check("a_done",   32'(done_a),         32'd1);
    check("a_busy",   32'(busy_a),         32'd0);
    check("a_index",  32'(index_a),        32'd10);
    check("a_enable", 32'(ifa.I2C_ENABLE), 32'd0);
    check("a_words",  32'(log_a.size()),   32'd11);
    for (int i = 0; i < 11 && i < log_a.size(); i++)
      check($sformatf("a_word%0d", i), 32'(log_a[i]), 32'(EXP[i]));
    check("b_quiet_without_start", 32'(b_rises), 32'd0);
    gap_on = 1'b0;

    // Timeout on word 3
    log_a = {};
    nofin_a = 3;
    pulse_start_a();
    check("a_done_cleared", 32'(done_a), 32'd0);
    n = 0;
    while (!err_a && n < 30000) begin @(negedge clk); n++; end
    #1;
    check("to_error",   32'(err_a),                    32'd1);
    check("to_latency", 32'(err_rise_a - last_rise_a), 32'(TO_A));
    check("to_enable",  32'(ifa.I2C_ENABLE),           32'd0);
    check("to_index",   32'(index_a),                  32'd3);
    check("to_busy",    32'(busy_a),                   32'd0);
    check("to_words",   32'(log_a.size()),             32'd4);

    // Restart from error
    nofin_a = -1;
    log_a = {};
    pulse_start_a();
    check("rs_error_cleared", 32'(err_a),          32'd0);
    check("rs_enable_low",    32'(ifa.I2C_ENABLE), 32'd0);
    @(negedge clk);
    check("rs_enable_high",   32'(ifa.I2C_ENABLE), 32'd1);
    check("rs_data",          32'(ifa.I2C_DATA),   32'h1E00);

    // START while busy is ignored
    n = 0;
    while (index_a != 4'd2 && n < 20000) begin @(negedge clk); n++; end
    pulse_start_a();
    repeat (3) @(negedge clk);
    check("busy_start_index", 32'(index_a), 32'd2);
    check("busy_start_busy",  32'(busy_a),  32'd1);

    // Reset in the middle of word 5
    n = 0;
    while (!(index_a == 4'd5 && ifa.I2C_ENABLE) && n < 20000) begin @(negedge clk); n++; end
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_enable", 32'(ifa.I2C_ENABLE), 32'd0);
    check("mid_rst_data",   32'(ifa.I2C_DATA),   32'h0000);
    check("mid_rst_busy",   32'(busy_a),         32'd0);
    check("mid_rst_index",  32'(index_a),        32'd0);
    repeat (2) @(negedge clk);
    log_a = {};
    rst_n = 1'b1;
    n = 0;
    while (log_a.size() == 0 && n < 100) begin @(negedge clk); n++; end
    #1;
    check("mid_rst_restart_words", 32'(log_a.size() > 0), 32'd1);
    if (log_a.size() > 0) check("mid_rst_restart_data", 32'(log_a[0]), 32'h1E00);

    // Manual-start instance
    check("b_quiet_before_start", 32'(b_rises), 32'd0);
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    n = 0;
    while (!done_b && n < 30000) begin @(negedge clk); n++; end
    #1;
    check("b_done",  32'(done_b),       32'd1);
    check("b_busy",  32'(busy_b),       32'd0);
    check("b_error", 32'(err_b),        32'd0);
    check("b_index", 32'(index_b),      32'd10);
    check("b_words", 32'(log_b.size()), 32'd11);
    for (int i = 0; i < 11 && i < log_b.size(); i++)
      check($sformatf("b_word%0d", i), 32'(log_b[i]), 32'(EXP[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
